// File: rtl/vx_commit_timeit_pkg.sv
// Shared types and sizing helpers for the commit/timeit block.
// Build option: TIMEIT_REENTRY_EN lets a finished warp window restart on a later start commit.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package VX_timeit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } timeit_state_t;

  // Width that holds every lane of every port retiring at once.
  function automatic int csize_w(input int num_exu, input int num_threads);
    return $clog2(num_exu * num_threads + 1);
  endfunction

  // Warp id width, never narrower than one bit.
  function automatic int nw_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/VX_popcount.sv
// Combinational population count of an N-bit vector.
module VX_popcount #(
  parameter int N     = 4,
  parameter int OUT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     data_in,
  output logic [OUT_W-1:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      data_out = data_out + OUT_W'(data_in[i]);
    end
  end

endmodule

// File: rtl/vx_commit_timeit_warp_fsm.sv
// Per-warp timeit window tracker: IDLE -> ACTIVE on start, ACTIVE -> DONE on end.
// Build option: TIMEIT_REENTRY_EN allows DONE -> ACTIVE on a later start.
module VX_timeit_warp_fsm
  import VX_timeit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic enable_rise,
  input  logic start_hit,
  input  logic end_hit,
  output logic active
);

  timeit_state_t state_q, state_d;
  logic          active_q, active_d;

  always_comb begin
    state_d = state_q;
    // Disabled or freshly re-armed: every warp restarts from IDLE.
    if (!enable || enable_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_hit) state_d = ACTIVE;
        ACTIVE:  if (end_hit)   state_d = DONE;
        DONE: begin
`ifdef TIMEIT_REENTRY_EN
          if (start_hit) state_d = ACTIVE;
`else
          state_d = DONE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/vx_commit_timeit.sv
// Commit-stage master of the CSR commit interface: retired-lane count plus per-warp timeit gating.
// Build option: TIMEIT_REENTRY_EN (see VX_timeit_warp_fsm).
module vx_commit_timeit
  import VX_timeit_pkg::*;
#(
  parameter int NUM_EXU     = 5,
  parameter int NUM_WARPS   = `NUM_WARPS,
  parameter int NUM_THREADS = `NUM_THREADS,
  parameter int NW_BITS     = nw_bits(NUM_WARPS),
  parameter int CSIZE_W     = csize_w(NUM_EXU, NUM_THREADS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_EXU-1:0]             commit_fire,
  input  logic [NUM_EXU*NW_BITS-1:0]     commit_wid,
  input  logic [NUM_EXU*NUM_THREADS-1:0] commit_tmask,
  input  logic [NUM_EXU*32-1:0]          commit_pc,
  input  logic [NUM_EXU-1:0]             commit_eop,
  input  logic                           timeit_enable,
  input  logic [31:0]                    timeit_start_addr,
  input  logic [31:0]                    timeit_end_addr,
  output logic                           valid,
  output logic [CSIZE_W-1:0]             commit_size,
  output logic [NUM_WARPS-1:0]           timeit_active
);

  localparam int PCNT_W = $clog2(NUM_THREADS + 1);

  logic [NUM_EXU-1:0] contrib;
  logic [PCNT_W-1:0]  port_cnt [NUM_EXU];

  logic               valid_q, valid_d;
  logic [CSIZE_W-1:0] size_q, size_d;
  logic               en_hist_q, en_hist_d;
  logic               enable_rise;

  // Only the final packet of an instruction retires its lanes.
  assign contrib = commit_fire & commit_eop;

  for (genvar gi = 0; gi < NUM_EXU; gi++) begin : g_pcnt
    VX_popcount #(
      .N     (NUM_THREADS),
      .OUT_W (PCNT_W)
    ) u_popcount (
      .data_in  (commit_tmask[gi*NUM_THREADS +: NUM_THREADS]),
      .data_out (port_cnt[gi])
    );
  end

  always_comb begin
    size_d = '0;
    for (int k = 0; k < NUM_EXU; k++) begin
      if (contrib[k]) size_d = size_d + CSIZE_W'(port_cnt[k]);
    end
    valid_d   = |contrib;
    en_hist_d = timeit_enable;
  end

  assign enable_rise = timeit_enable && !en_hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      size_q    <= '0;
      en_hist_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      size_q    <= size_d;
      en_hist_q <= en_hist_d;
    end
  end

  assign valid       = valid_q;
  assign commit_size = size_q;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic start_hit, end_hit;

    // Several ports may hit the same warp in one cycle; OR them per event type.
    always_comb begin
      start_hit = 1'b0;
      end_hit   = 1'b0;
      for (int k = 0; k < NUM_EXU; k++) begin
        if (contrib[k] && (commit_wid[k*NW_BITS +: NW_BITS] == NW_BITS'(gi))) begin
          if (commit_pc[k*32 +: 32] == timeit_start_addr) start_hit = 1'b1;
          if (commit_pc[k*32 +: 32] == timeit_end_addr)   end_hit   = 1'b1;
        end
      end
    end

    VX_timeit_warp_fsm u_fsm (
      .clk         (clk),
      .reset       (reset),
      .enable      (timeit_enable),
      .enable_rise (enable_rise),
      .start_hit   (start_hit),
      .end_hit     (end_hit),
      .active      (timeit_active[gi])
    );
  end

endmodule

// File: tb/tb_vx_commit_timeit.sv
// Self-checking bench for vx_commit_timeit: directed scenarios then random traffic against a window model.
module tb_vx_commit_timeit;

  localparam int NE  = 5;
  localparam int NWP = 4;
  localparam int NT  = 4;
  localparam int NWB = 2;
  localparam int CW  = $clog2(NE * NT + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NE-1:0]        commit_fire;
  logic [NE*NWB-1:0]    commit_wid;
  logic [NE*NT-1:0]     commit_tmask;
  logic [NE*32-1:0]     commit_pc;
  logic [NE-1:0]        commit_eop;
  logic                 timeit_enable;
  logic [31:0]          timeit_start_addr;
  logic [31:0]          timeit_end_addr;
  logic                 valid;
  logic [CW-1:0]        commit_size;
  logic [NWP-1:0]       timeit_active;

  int checks = 0;
  int errors = 0;

  // Model state: which warps are inside a window, which have closed one.
  bit [NWP-1:0] m_in_win;
  bit [NWP-1:0] m_closed;
  bit           m_en_prev;
  bit           exp_valid;
  int           exp_size;
  bit [NWP-1:0] exp_active;

  vx_commit_timeit #(
    .NUM_EXU     (NE),
    .NUM_WARPS   (NWP),
    .NUM_THREADS (NT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .commit_fire       (commit_fire),
    .commit_wid        (commit_wid),
    .commit_tmask      (commit_tmask),
    .commit_pc         (commit_pc),
    .commit_eop        (commit_eop),
    .timeit_enable     (timeit_enable),
    .timeit_start_addr (timeit_start_addr),
    .timeit_end_addr   (timeit_end_addr),
    .valid             (valid),
    .commit_size       (commit_size),
    .timeit_active     (timeit_active)
  );

  always #5 clk = ~clk;

  task automatic clear_ports();
    commit_fire  = '0;
    commit_eop   = '0;
    commit_wid   = '0;
    commit_tmask = '0;
    commit_pc    = '0;
  endtask

  task automatic set_port(input int k, input bit f, input bit e, input int w,
                          input logic [NT-1:0] m, input logic [31:0] pc);
    commit_fire[k]              = f;
    commit_eop[k]               = e;
    commit_wid[k*NWB +: NWB]    = NWB'(w);
    commit_tmask[k*NT +: NT]    = m;
    commit_pc[k*32 +: 32]       = pc;
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock: predict outputs from the inputs present now, then compare after the edge.
  task automatic step(input string tag);
    bit [NWP-1:0] sh, eh;
    int w;
    sh = '0;
    eh = '0;
    exp_valid = 1'b0;
    exp_size  = 0;
    for (int k = 0; k < NE; k++) begin
      if (commit_fire[k] && commit_eop[k]) begin
        exp_valid = 1'b1;
        exp_size += $countones(commit_tmask[k*NT +: NT]);
        w = int'(commit_wid[k*NWB +: NWB]);
        if (commit_pc[k*32 +: 32] == timeit_start_addr) sh[w] = 1'b1;
        if (commit_pc[k*32 +: 32] == timeit_end_addr)   eh[w] = 1'b1;
      end
    end
    if (!reset) begin
      exp_valid = 1'b0;
      exp_size  = 0;
      m_in_win  = '0;
      m_closed  = '0;
      m_en_prev = 1'b0;
    end else begin
      for (int i = 0; i < NWP; i++) begin
        if (!timeit_enable || !m_en_prev) begin
          m_in_win[i] = 1'b0;
          m_closed[i] = 1'b0;
        end else if (m_in_win[i]) begin
          if (eh[i]) begin
            m_in_win[i] = 1'b0;
            m_closed[i] = 1'b1;
          end
        end else if (!m_closed[i]) begin
          if (sh[i]) m_in_win[i] = 1'b1;
        end else begin
`ifdef TIMEIT_REENTRY_EN
          if (sh[i]) begin
            m_in_win[i] = 1'b1;
            m_closed[i] = 1'b0;
          end
`endif
        end
      end
      m_en_prev = timeit_enable;
    end
    exp_active = m_in_win;
    @(posedge clk);
    #1;
    check_val({tag, ".valid"},  int'(valid),         int'(exp_valid));
    check_val({tag, ".size"},   int'(commit_size),   exp_size);
    check_val({tag, ".active"}, int'(timeit_active), int'(exp_active));
  endtask

  initial begin
    logic [31:0] pc_pick;
    reset             = 1'b0;
    timeit_enable     = 1'b0;
    timeit_start_addr = 32'h8000_0100;
    timeit_end_addr   = 32'h8000_0200;
    clear_ports();
    m_in_win  = '0;
    m_closed  = '0;
    m_en_prev = 1'b0;

    // Reset held with every port firing: outputs must stay quiet.
    commit_fire  = '1;
    commit_eop   = '1;
    commit_tmask = '1;
    for (int c = 0; c < 3; c++) step("reset_hold");
    reset = 1'b1;
    clear_ports();
    step("after_release");

    // Retire path: eop gating and popcount sum.
    set_port(0, 1, 1, 0, 4'b1011, 32'h0);
    set_port(1, 1, 0, 0, 4'b1111, 32'h0);
    set_port(2, 1, 1, 1, 4'b1111, 32'h0);
    step("retire_mix");
    check_val("retire_mix.size7", int'(commit_size), 7);
    clear_ports();
    step("retire_idle");
    check_val("retire_idle.valid0", int'(valid), 0);

    // Warp 1 window: start at t, end at t+10.
    timeit_enable = 1'b1;
    step("enable_rise");
    set_port(3, 1, 1, 1, 4'b0001, 32'h8000_0100);
    step("w1_start");
    check_val("w1_start.bit", int'(timeit_active[1]), 1);
    clear_ports();
    for (int c = 0; c < 9; c++) step("w1_inside");
    check_val("w1_last_cycle.bit", int'(timeit_active), 4'b0010);
    set_port(0, 1, 1, 1, 4'b0001, 32'h8000_0200);
    step("w1_end");
    check_val("w1_end.bit", int'(timeit_active[1]), 0);
    clear_ports();

    // start == end on warp 0.
    timeit_start_addr = 32'h8000_0300;
    timeit_end_addr   = 32'h8000_0300;
    set_port(1, 1, 1, 0, 4'b0011, 32'h8000_0300);
    step("w0_same_start");
    check_val("w0_same_start.bit", int'(timeit_active[0]), 1);
    clear_ports();
    for (int c = 0; c < 3; c++) step("w0_same_inside");
    set_port(4, 1, 1, 0, 4'b0011, 32'h8000_0300);
    step("w0_same_end");
    check_val("w0_same_end.bit", int'(timeit_active[0]), 0);
    clear_ports();

    // Enable drop mid-window on warp 2, then re-arm and start again.
    timeit_start_addr = 32'h8000_0100;
    timeit_end_addr   = 32'h8000_0200;
    set_port(2, 1, 1, 2, 4'b1000, 32'h8000_0100);
    step("w2_start");
    clear_ports();
    step("w2_inside");
    timeit_enable = 1'b0;
    step("w2_disable");
    check_val("w2_disable.bit", int'(timeit_active[2]), 0);
    timeit_enable = 1'b1;
    step("w2_rearm");
    set_port(2, 1, 1, 2, 4'b1000, 32'h8000_0100);
    step("w2_restart");
    check_val("w2_restart.bit", int'(timeit_active[2]), 1);
    clear_ports();

    // Warp 3: close a window, then a second start.
    set_port(0, 1, 1, 3, 4'b0100, 32'h8000_0100);
    step("w3_start");
    set_port(0, 1, 1, 3, 4'b0100, 32'h8000_0200);
    step("w3_end");
    set_port(0, 1, 1, 3, 4'b0100, 32'h8000_0100);
    step("w3_second_start");
`ifdef TIMEIT_REENTRY_EN
    check_val("w3_second_start.bit", int'(timeit_active[3]), 1);
`else
    check_val("w3_second_start.bit", int'(timeit_active[3]), 0);
`endif
    clear_ports();
    step("w3_idle");

    // Random traffic, occasional enable toggles, address changes and resets.
    for (int c = 0; c < 400; c++) begin
      clear_ports();
      for (int k = 0; k < NE; k++) begin
        case ($urandom_range(0, 3))
          0: pc_pick = timeit_start_addr;
          1: pc_pick = timeit_end_addr;
          2: pc_pick = timeit_start_addr + 32'd4;
          default: pc_pick = $urandom;
        endcase
        set_port(k, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, NWP - 1), NT'($urandom), pc_pick);
      end
      if ($urandom_range(0, 39) == 0) timeit_enable = ~timeit_enable;
      if ($urandom_range(0, 59) == 0) begin
        timeit_start_addr = 32'h8000_0000 + 32'($urandom_range(0, 3) * 16);
        timeit_end_addr   = 32'h8000_0000 + 32'($urandom_range(0, 3) * 16);
      end
      reset = ($urandom_range(0, 99) != 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_commit_timeit.md
Name: VX_commit_timeit

Overview:
- Master end of the commit-to-CSR interface.
- Gathers per-execution-unit commit events and produces the registered `valid` / `commit_size` pair that feeds the instret counter.
- Runs one timeit FSM per warp, watching committed PCs against the programmed start/end addresses, and drives `timeit_active[NUM_WARPS]` to gate the per-warp timeit cycle counters.
- Sits in the commit stage, between the EXU commit ports and the CSR data block.

Parameters:
- NUM_EXU, 5, number of commit ports (ALU, LSU, CSR, FPU, GPU).
- NUM_WARPS, `NUM_WARPS, number of warps tracked.
- NUM_THREADS, `NUM_THREADS, lanes per commit port.
- CSIZE_W, $clog2(NUM_EXU*NUM_THREADS+1), width of commit_size.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when reset==0).
- commit_fire  in  NUM_EXU  port k commits this cycle (valid&&ready already resolved upstream).
- commit_wid  in  NUM_EXU x `NW_BITS  warp id per port.
- commit_tmask  in  NUM_EXU x NUM_THREADS  active lanes per port.
- commit_pc  in  NUM_EXU x 32  PC of committed instruction.
- commit_eop  in  NUM_EXU  last packet of the instruction.
- timeit_enable  in  1  timeit window armed (from CSR data block).
- timeit_start_addr  in  32  window start PC.
- timeit_end_addr  in  32  window end PC.
- valid  out  1  commit_size is meaningful this cycle.
- commit_size  out  CSIZE_W  number of lanes retired.
- timeit_active  out  NUM_WARPS  warp i is inside its timed window.

Behaviour:
- Reset:
  - `valid`=0, `commit_size`=0, `timeit_active`=0.
  - All warp FSMs go to IDLE; the `timeit_enable` history register is cleared to 0.
  - Reset asserted mid-window returns every FSM to IDLE next edge with no residual active bit.
- Retire path:
  - A port contributes only when `commit_fire` && `commit_eop`.
  - `commit_size` is the sum of popcount(`commit_tmask`) over contributing ports, zero-extended to CSIZE_W; no overflow is possible by width choice.
  - `valid` = any contributing port.
  - Both outputs are registered, 1-cycle latency. With no contributing port: `valid`=0 and `commit_size`=0.
- Per-warp FSM states: IDLE, ACTIVE, DONE. For warp i, any contributing port with `commit_wid`==i is a hit:
  - start_hit: a hit with `commit_pc`==`timeit_start_addr`.
  - end_hit: a hit with `commit_pc`==`timeit_end_addr`.
- Transitions, evaluated only while `timeit_enable`=1:
  - IDLE -> ACTIVE on start_hit. A simultaneous end_hit in the same cycle is ignored, including when start==end.
  - ACTIVE -> DONE on end_hit. A start_hit while ACTIVE is ignored.
  - DONE is held; see Optional Feature.
- Enable control:
  - `timeit_enable`=0: all FSMs are forced to IDLE next edge.
  - A rising edge of `timeit_enable` (registered history 0 -> 1) forces IDLE in that cycle, so re-programming restarts every warp.
- `timeit_active[i]` is a register equal to (next state == ACTIVE):
  - goes high the cycle after the start commit;
  - stays high through the cycle after the end commit's edge, so the end commit cycle is counted;
  - then drops.
- Warps are independent. Several ports hitting the same warp in one cycle are OR-reduced per event type.

Optional Feature:
- Macro: TIMEIT_REENTRY_EN.
- Defined: DONE -> ACTIVE on a later start_hit, so multiple start/end intervals accumulate in the downstream counter while enable stays high.
- Undefined: DONE is sticky until enable falls, rises again, or reset; later start_hits are ignored.

Decomposition:
- Package VX_timeit_pkg holds:
  - timeit_state_t enum (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2);
  - CSIZE_W helper function.
- Sub-module VX_timeit_warp_fsm: one instance per warp, taking start_hit, end_hit, enable and enable_rise, and producing `active`.
- Popcount uses the existing VX_popcount.

Test Plan:
- Reset held low 3 cycles with `commit_fire`=all ones -> `valid`=0, `commit_size`=0, `timeit_active`=0 throughout; first output follows 1 cycle after release.
- Ports 0 and 2 fire with eop, tmask 4'b1011 and 4'b1111; port 1 fires with eop=0 -> next cycle `valid`=1, `commit_size`=7.
- enable=1, start=0x80000100, end=0x80000200. Warp 1 commits 0x100 at cycle t and 0x200 at t+10 -> `timeit_active[1]` high cycles t+1..t+10, other bits 0.
- start==end=0x80000300, warp 0 commits that PC at t and again at t+4 -> ACTIVE from t+1, DONE after t+4 (active low at t+5).
- Enable dropped while warp 2 is ACTIVE -> `active[2]`=0 next cycle. Re-enable, then a start hit -> active again.
- After DONE, a second start hit on warp 3 -> `active[3]` stays 0 without TIMEIT_REENTRY_EN, goes high next cycle with it.
